// File: rtl/ysyx_24090003_wbu.sv
// ysyx_24090003_wbu: write-back unit.
// Arbitrates EXU and LSU results onto the GPR write port with one registered
// write per cycle. LSU has priority, and a starvation counter guarantees the
// EXU a slot after STARVE_MAX consecutive losses. It also keeps a per-register
// pending-write scoreboard so the IDU can stall on RAW hazards.
// Optional feature macro: YSYX_24090003_WBU_BYPASS_EN. It forwards the
// write-back data to a source operand whose last pending write is retiring.

module ysyx_24090003_wbu #(
    parameter int unsigned CNT_W      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_exu_valid,
    output logic        o_exu_ready,
    input  logic [4:0]  i_exu_rd,
    input  logic [31:0] i_exu_data,
    input  logic        i_exu_wen,
    input  logic        i_lsu_valid,
    output logic        o_lsu_ready,
    input  logic [4:0]  i_lsu_rd,
    input  logic [31:0] i_lsu_data,
    input  logic        i_lsu_wen,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_rd,
    output logic        o_issue_ready,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic        o_stall,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_wdata,
    output logic        o_reg_wen,
    output logic        o_sb_err
`ifdef YSYX_24090003_WBU_BYPASS_EN
    ,
    output logic        o_rs1_fwd,
    output logic        o_rs2_fwd,
    output logic [31:0] o_fwd_data
`endif
);

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);

    // Registered write port and bookkeeping state
    logic [AW-1:0]    r_rd_addr;
    logic [DW-1:0]    r_rd_wdata;
    logic             r_reg_wen;
    logic [SW-1:0]    r_starve;
    logic             r_sb_err;
    logic [CNT_W-1:0] r_cnt [NREG];

    // Arbitration and scoreboard combinational terms
    logic             w_both_valid;
    logic             w_exu_force;
    logic             w_exu_ready;
    logic             w_lsu_ready;
    logic             w_exu_xfer;
    logic             w_lsu_xfer;
    logic [SW-1:0]    w_starve_nxt;
    logic             w_issue_dec_hit;
    logic             w_issue_ready;
    logic             w_issue_rej;
    logic             w_inc;
    logic [NREG-1:0]  w_inc_vec;
    logic [NREG-1:0]  w_dec_vec;
    logic [CNT_W-1:0] w_cnt_nxt [NREG];
    logic             w_underflow;
    logic             w_rs1_busy;
    logic             w_rs2_busy;
    logic             w_rs1_fwd;
    logic             w_rs2_fwd;

    // Grant selection: LSU wins unless the EXU has been starved long enough
    always_comb begin
        w_both_valid = i_exu_valid && i_lsu_valid;
        w_exu_force  = w_both_valid && (r_starve == STARVE_LIM);
        w_lsu_ready  = !w_exu_force;
        w_exu_ready  = !i_lsu_valid || w_exu_force;
        w_exu_xfer   = i_exu_valid && w_exu_ready;
        w_lsu_xfer   = i_lsu_valid && w_lsu_ready;
    end

    // Starvation count: consecutive cycles the EXU waited behind the LSU
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_both_valid && w_lsu_xfer) begin
            w_starve_nxt = r_starve + SW'(1);
        end else if (w_exu_xfer || !i_exu_valid) begin
            w_starve_nxt = '0;
        end
    end

    // Issue acceptance: a full counter only frees up through a same-cycle retire
    always_comb begin
        w_issue_dec_hit = r_reg_wen && (r_rd_addr == i_issue_rd);
        w_issue_ready   = !((r_cnt[i_issue_rd] == CNT_MAX) && !w_issue_dec_hit);
        w_issue_rej     = i_issue_valid && !w_issue_ready;
        w_inc           = i_issue_valid && w_issue_ready && (i_issue_rd != '0);
        w_inc_vec       = w_inc ? (NREG'(1) << i_issue_rd) : '0;
        w_dec_vec       = r_reg_wen ? (NREG'(1) << r_rd_addr) : '0;
    end

    // Per-register counter update; x0 is never tracked
    always_comb begin
        w_underflow = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
        end
        w_cnt_nxt[0] = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            case ({w_inc_vec[i], w_dec_vec[i]})
                2'b10: w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                2'b01: begin
                    if (r_cnt[i] == '0) begin
                        w_underflow = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
                    end
                end
                default: w_cnt_nxt[i] = r_cnt[i];
            endcase
        end
    end

    // RAW hazard detection, with optional forwarding of the retiring write
    always_comb begin
        w_rs1_busy = (i_rs1_addr != '0) && (r_cnt[i_rs1_addr] != '0);
        w_rs2_busy = (i_rs2_addr != '0) && (r_cnt[i_rs2_addr] != '0);
        w_rs1_fwd  = 1'b0;
        w_rs2_fwd  = 1'b0;
`ifdef YSYX_24090003_WBU_BYPASS_EN
        w_rs1_fwd  = r_reg_wen && (r_rd_addr == i_rs1_addr) && (r_cnt[i_rs1_addr] == CNT_ONE);
        w_rs2_fwd  = r_reg_wen && (r_rd_addr == i_rs2_addr) && (r_cnt[i_rs2_addr] == CNT_ONE);
`endif
    end

    // Registered write toward the regfile; reset drops any in-flight write
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_reg_wen  <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_wdata <= '0;
        end else if (w_exu_xfer) begin
            r_reg_wen  <= i_exu_wen && (i_exu_rd != '0);
            r_rd_addr  <= i_exu_rd;
            r_rd_wdata <= i_exu_data;
        end else if (w_lsu_xfer) begin
            r_reg_wen  <= i_lsu_wen && (i_lsu_rd != '0);
            r_rd_addr  <= i_lsu_rd;
            r_rd_wdata <= i_lsu_data;
        end else begin
            r_reg_wen  <= 1'b0;
        end
    end

    // Scoreboard counters, starvation counter and sticky error flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_starve <= '0;
            r_sb_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_starve <= w_starve_nxt;
            r_sb_err <= r_sb_err || w_underflow || w_issue_rej;
        end
    end

    assign o_exu_ready   = w_exu_ready;
    assign o_lsu_ready   = w_lsu_ready;
    assign o_issue_ready = w_issue_ready;
    assign o_stall       = (w_rs1_busy && !w_rs1_fwd) || (w_rs2_busy && !w_rs2_fwd);
    assign o_rd_addr     = r_rd_addr;
    assign o_rd_wdata    = r_rd_wdata;
    assign o_reg_wen     = r_reg_wen;
    assign o_sb_err      = r_sb_err;

`ifdef YSYX_24090003_WBU_BYPASS_EN
    assign o_rs1_fwd     = w_rs1_fwd;
    assign o_rs2_fwd     = w_rs2_fwd;
    assign o_fwd_data    = r_rd_wdata;
`endif

endmodule

// File: tb/tb_ysyx_24090003_wbu.sv
// Testbench for ysyx_24090003_wbu: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a reference model.
module tb_ysyx_24090003_wbu;

    localparam int unsigned CNT_W      = 2;
    localparam int unsigned STARVE_MAX = 4;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_exu_valid;
    logic        o_exu_ready;
    logic [4:0]  i_exu_rd;
    logic [31:0] i_exu_data;
    logic        i_exu_wen;
    logic        i_lsu_valid;
    logic        o_lsu_ready;
    logic [4:0]  i_lsu_rd;
    logic [31:0] i_lsu_data;
    logic        i_lsu_wen;
    logic        i_issue_valid;
    logic [4:0]  i_issue_rd;
    logic        o_issue_ready;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic        o_stall;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_wdata;
    logic        o_reg_wen;
    logic        o_sb_err;
`ifdef YSYX_24090003_WBU_BYPASS_EN
    logic        o_rs1_fwd;
    logic        o_rs2_fwd;
    logic [31:0] o_fwd_data;
`endif

    ysyx_24090003_wbu #(
        .CNT_W      (CNT_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_exu_valid   (i_exu_valid),
        .o_exu_ready   (o_exu_ready),
        .i_exu_rd      (i_exu_rd),
        .i_exu_data    (i_exu_data),
        .i_exu_wen     (i_exu_wen),
        .i_lsu_valid   (i_lsu_valid),
        .o_lsu_ready   (o_lsu_ready),
        .i_lsu_rd      (i_lsu_rd),
        .i_lsu_data    (i_lsu_data),
        .i_lsu_wen     (i_lsu_wen),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .o_issue_ready (o_issue_ready),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .o_stall       (o_stall),
        .o_rd_addr     (o_rd_addr),
        .o_rd_wdata    (o_rd_wdata),
        .o_reg_wen     (o_reg_wen),
        .o_sb_err      (o_sb_err)
`ifdef YSYX_24090003_WBU_BYPASS_EN
        ,
        .o_rs1_fwd     (o_rs1_fwd),
        .o_rs2_fwd     (o_rs2_fwd),
        .o_fwd_data    (o_fwd_data)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp;
    int n_bad;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending write counts per register, arbitration history
    // and the write that the regfile port is presenting this cycle.
    int          m_pend [32];
    int          m_starve;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_err;
    bit          m_live;

    bit e_both, e_exu_wins, e_lsu_wins, e_exu_ready, e_lsu_ready;
    bit e_issue_ready, e_stall, e_fwd1, e_fwd2, e_fire;
    int n_new;

    function automatic bit fwd_ok(input logic [4:0] rs);
`ifdef YSYX_24090003_WBU_BYPASS_EN
        return m_wen && (m_addr == rs) && (m_pend[rs] == 1);
`else
        return (rs != rs);
`endif
    endfunction

    function automatic bit busy(input logic [4:0] rs);
        return (rs != 5'd0) && (m_pend[rs] != 0) && !fwd_ok(rs);
    endfunction

    // Compare every output with the model, then advance the model one edge
    always @(negedge i_clk) begin
        e_both        = i_exu_valid && i_lsu_valid;
        e_exu_wins    = i_exu_valid && (!i_lsu_valid || (m_starve == STARVE_MAX));
        e_lsu_wins    = i_lsu_valid && !e_exu_wins;
        e_lsu_ready   = !(e_both && (m_starve == STARVE_MAX));
        e_exu_ready   = !i_lsu_valid || (e_both && (m_starve == STARVE_MAX));
        e_issue_ready = !((m_pend[i_issue_rd] == CNT_MAX) && !(m_wen && (m_addr == i_issue_rd)));
        e_stall       = busy(i_rs1_addr) || busy(i_rs2_addr);
        e_fwd1        = fwd_ok(i_rs1_addr);
        e_fwd2        = fwd_ok(i_rs2_addr);
        if (m_live) begin
            chk1("m_exu_ready", o_exu_ready, e_exu_ready);
            chk1("m_lsu_ready", o_lsu_ready, e_lsu_ready);
            chk1("m_issue_ready", o_issue_ready, e_issue_ready);
            chk1("m_stall", o_stall, e_stall);
            chk1("m_reg_wen", o_reg_wen, m_wen);
            chk32("m_rd_addr", 32'(o_rd_addr), 32'(m_addr));
            chk32("m_rd_wdata", o_rd_wdata, m_data);
            chk1("m_sb_err", o_sb_err, m_err);
`ifdef YSYX_24090003_WBU_BYPASS_EN
            chk1("m_rs1_fwd", o_rs1_fwd, e_fwd1);
            chk1("m_rs2_fwd", o_rs2_fwd, e_fwd2);
            chk32("m_fwd_data", o_fwd_data, m_data);
`endif
        end
        if (!i_rst_n) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 0;
            m_starve = 0;
            m_wen    = 1'b0;
            m_addr   = 5'd0;
            m_data   = 32'd0;
            m_err    = 1'b0;
            m_live   = 1'b1;
        end else begin
            e_fire = i_issue_valid && e_issue_ready && (i_issue_rd != 5'd0);
            if (i_issue_valid && !e_issue_ready) m_err = 1'b1;
            for (int r = 1; r < 32; r++) begin
                n_new = m_pend[r];
                if (e_fire && (i_issue_rd == 5'(r))) n_new = n_new + 1;
                if (m_wen && (m_addr == 5'(r)))     n_new = n_new - 1;
                if (n_new < 0) begin
                    n_new = 0;
                    m_err = 1'b1;
                end
                m_pend[r] = n_new;
            end
            if (e_exu_wins) begin
                m_wen  = i_exu_wen && (i_exu_rd != 5'd0);
                m_addr = i_exu_rd;
                m_data = i_exu_data;
            end else if (e_lsu_wins) begin
                m_wen  = i_lsu_wen && (i_lsu_rd != 5'd0);
                m_addr = i_lsu_rd;
                m_data = i_lsu_data;
            end else begin
                m_wen  = 1'b0;
            end
            if (e_both && e_lsu_wins)            m_starve = m_starve + 1;
            else if (e_exu_wins || !i_exu_valid) m_starve = 0;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_exu_valid   = 1'b0;
        i_exu_rd      = 5'd0;
        i_exu_data    = 32'd0;
        i_exu_wen     = 1'b0;
        i_lsu_valid   = 1'b0;
        i_lsu_rd      = 5'd0;
        i_lsu_data    = 32'd0;
        i_lsu_wen     = 1'b0;
        i_issue_valid = 1'b0;
        i_issue_rd    = 5'd0;
        i_rs1_addr    = 5'd0;
        i_rs2_addr    = 5'd0;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        m_live = 1'b0;
        i_rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();

        // Reset state
        i_rst_n = 1'b1;
        #1;
        chk1("rst_wen", o_reg_wen, 1'b0);
        chk32("rst_addr", 32'(o_rd_addr), 32'd0);
        chk32("rst_data", o_rd_wdata, 32'd0);
        chk1("rst_err", o_sb_err, 1'b0);
        chk1("rst_issue_ready", o_issue_ready, 1'b1);

        // Reset arriving while a write is in flight
        i_issue_valid = 1'b1; i_issue_rd = 5'd5;
        tick();
        i_issue_valid = 1'b0; i_rs1_addr = 5'd5;
        #1;
        chk1("t1_pending", o_stall, 1'b1);
        i_exu_valid = 1'b1; i_exu_rd = 5'd5; i_exu_data = 32'h1234; i_exu_wen = 1'b1;
        tick();
        i_exu_valid = 1'b0;
        #1;
        chk1("t1_wen", o_reg_wen, 1'b1);
        chk32("t1_data", o_rd_wdata, 32'h1234);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        #1;
        chk1("t1_rst_wen", o_reg_wen, 1'b0);
        chk32("t1_rst_data", o_rd_wdata, 32'd0);
        chk1("t1_rst_stall", o_stall, 1'b0);
        chk1("t1_rst_err", o_sb_err, 1'b0);

        // Single EXU write clears the hazard one edge after the write is presented
        i_issue_valid = 1'b1; i_issue_rd = 5'd3; i_rs1_addr = 5'd3;
        tick();
        i_issue_valid = 1'b0;
        i_exu_valid = 1'b1; i_exu_rd = 5'd3; i_exu_data = 32'hDEADBEEF; i_exu_wen = 1'b1;
        #1;
        chk1("t2_stall_issue", o_stall, 1'b1);
        tick();
        i_exu_valid = 1'b0;
        #1;
        chk1("t2_wen", o_reg_wen, 1'b1);
        chk32("t2_addr", 32'(o_rd_addr), 32'd3);
        chk32("t2_data", o_rd_wdata, 32'hDEADBEEF);
`ifdef YSYX_24090003_WBU_BYPASS_EN
        chk1("t2_stall_wb", o_stall, 1'b0);
        chk1("t2_fwd", o_rs1_fwd, 1'b1);
`else
        chk1("t2_stall_wb", o_stall, 1'b1);
`endif
        tick();
        #1;
        chk1("t2_stall_done", o_stall, 1'b0);
        chk1("t2_wen_idle", o_reg_wen, 1'b0);
        chk32("t2_data_hold", o_rd_wdata, 32'hDEADBEEF);

        // Both producers valid every cycle: EXU gets the fifth slot
        i_rs1_addr = 5'd0;
        i_exu_valid = 1'b1; i_exu_rd = 5'd11; i_exu_data = 32'hE; i_exu_wen = 1'b0;
        i_lsu_valid = 1'b1; i_lsu_rd = 5'd10; i_lsu_data = 32'hA; i_lsu_wen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk1("t3_lsu_ready", o_lsu_ready, (k != 4));
            chk1("t3_exu_ready", o_exu_ready, (k == 4));
            tick();
            chk32("t3_addr", 32'(o_rd_addr), (k == 4) ? 32'd11 : 32'd10);
        end
        i_exu_valid = 1'b0; i_lsu_valid = 1'b0;
        tick();

        // Write to x0 is dropped and never tracked
        i_exu_valid = 1'b1; i_exu_rd = 5'd0; i_exu_wen = 1'b1; i_exu_data = 32'hFFFFFFFF;
        tick();
        i_exu_valid = 1'b0;
        #1;
        chk1("t4_wen", o_reg_wen, 1'b0);
        chk32("t4_data", o_rd_wdata, 32'hFFFFFFFF);
        chk1("t4_stall", o_stall, 1'b0);
        chk1("t4_err", o_sb_err, 1'b0);

        // Saturation, same-cycle retire relief and underflow
        i_issue_valid = 1'b1; i_issue_rd = 5'd7;
        repeat (3) tick();
        i_issue_valid = 1'b0;
        #1;
        chk1("t5_full", o_issue_ready, 1'b0);
        i_lsu_valid = 1'b1; i_lsu_rd = 5'd7; i_lsu_data = 32'd77; i_lsu_wen = 1'b1;
        tick();
        i_lsu_valid = 1'b0; i_issue_valid = 1'b1; i_issue_rd = 5'd7;
        #1;
        chk1("t5_relief", o_issue_ready, 1'b1);
        tick();
        i_issue_valid = 1'b0;
        #1;
        chk1("t5_still_full", o_issue_ready, 1'b0);
        chk1("t5_no_err", o_sb_err, 1'b0);
        i_exu_valid = 1'b1; i_exu_rd = 5'd12; i_exu_wen = 1'b1; i_exu_data = 32'd1;
        tick();
        i_exu_valid = 1'b0;
        #1;
        chk1("t5_err_pre", o_sb_err, 1'b0);
        tick();
        chk1("t5_underflow", o_sb_err, 1'b1);

`ifdef YSYX_24090003_WBU_BYPASS_EN
        // Forwarding of the retiring value when it is the only pending write
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        i_issue_valid = 1'b1; i_issue_rd = 5'd9;
        tick();
        i_issue_valid = 1'b0;
        i_exu_valid = 1'b1; i_exu_rd = 5'd9; i_exu_data = 32'h55; i_exu_wen = 1'b1;
        tick();
        i_exu_valid = 1'b0; i_rs2_addr = 5'd9;
        #1;
        chk1("t6_fwd", o_rs2_fwd, 1'b1);
        chk32("t6_fwd_data", o_fwd_data, 32'h55);
        chk1("t6_no_stall", o_stall, 1'b0);
        tick();
        i_issue_valid = 1'b1; i_issue_rd = 5'd9;
        repeat (2) tick();
        i_issue_valid = 1'b0;
        i_exu_valid = 1'b1;
        tick();
        i_exu_valid = 1'b0;
        #1;
        chk1("t6_stall2", o_stall, 1'b1);
        chk1("t6_nofwd2", o_rs2_fwd, 1'b0);
        i_rs2_addr = 5'd0;
`endif

        // Randomized traffic against the model
        idle_inputs();
        i_rst_n = 1'b0;
        tick();
        for (int c = 0; c < 3000; c++) begin
            i_rst_n       = ($urandom_range(0, 249) != 0);
            i_exu_valid   = ($urandom_range(0, 9) < 6);
            i_exu_rd      = 5'($urandom_range(0, 7));
            i_exu_data    = $urandom;
            i_exu_wen     = ($urandom_range(0, 9) < 8);
            i_lsu_valid   = ($urandom_range(0, 9) < 5);
            i_lsu_rd      = 5'($urandom_range(0, 7));
            i_lsu_data    = $urandom;
            i_lsu_wen     = ($urandom_range(0, 9) < 8);
            i_issue_valid = ($urandom_range(0, 9) < 5);
            i_issue_rd    = 5'($urandom_range(0, 7));
            i_rs1_addr    = 5'($urandom_range(0, 7));
            i_rs2_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            tick();
        end
        idle_inputs();
        i_rst_n = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
